// File: rtl/dcache_controller.sv
// Data-cache controller for the 2-way, 16-set, 256-bit-line SRAM.
// Handles hits in IDLE; misses go through write-back and refill.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  input  logic         sram_hit_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_REFILL,
    S_REFILL_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [255:0]   r_victim_line;
  logic [22:0]    r_victim_tag;
  logic [255:0]   r_refill_line;

  logic [22:0]    w_tag;
  logic [3:0]     w_index;
  logic [2:0]     w_word;
  logic [255:0]   w_merged;
  logic           w_stall;
  logic           w_unused;

  assign w_tag    = cpu_addr_i[31:9];
  assign w_index  = cpu_addr_i[8:5];
  assign w_word   = cpu_addr_i[4:2];
  assign w_unused = ^cpu_addr_i[1:0];

  assign sram_addr_o = w_index;
  assign cpu_data_o  = sram_data_i[{w_word, 5'b00000} +: 32];

  // Reset must drop the stall at once, even while a miss is outstanding.
  assign cpu_stall_o = w_stall & ~rst_i;

  always_comb begin
    w_merged = sram_data_i;
    w_merged[{w_word, 5'b00000} +: 32] = cpu_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_victim_line <= '0;
      r_victim_tag  <= '0;
      r_refill_line <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_MISS) begin
        r_victim_line <= sram_data_i;
        r_victim_tag  <= sram_tag_i[22:0];
      end
      if (r_state == S_REFILL && mem_ack_i) begin
        r_refill_line <= mem_data_i;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_stall       = 1'b1;
    sram_enable_o = 1'b1;
    sram_write_o  = 1'b0;
    sram_tag_o    = {2'b11, w_tag};
    sram_data_o   = w_merged;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    unique case (r_state)
      S_IDLE: begin
        sram_enable_o = cpu_req_i;
        w_stall       = cpu_req_i & ~sram_hit_i;
        sram_write_o  = cpu_req_i & sram_hit_i & cpu_write_i;
        if (cpu_req_i && !sram_hit_i) begin
          w_next = S_MISS;
        end
      end
      S_MISS: begin
        if (sram_tag_i[24] && sram_tag_i[23]) begin
          w_next = S_WRITEBACK;
        end else begin
          w_next = S_REFILL;
        end
      end
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_victim_tag, w_index, 5'b00000};
        mem_data_o   = r_victim_line;
        if (mem_ack_i) begin
          w_next = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {w_tag, w_index, 5'b00000};
        if (mem_ack_i) begin
          w_next = S_REFILL_DONE;
        end
      end
      S_REFILL_DONE: begin
        sram_write_o = 1'b1;
        sram_data_o  = r_refill_line;
        sram_tag_o   = {2'b10, w_tag};
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: SRAM and memory models plus a
// word-level golden memory with dirty-line tracking.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
    .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o),
    .sram_write_o(sram_write_o), .sram_tag_i(sram_tag_i),
    .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Golden word memory (latest values) and backing DRAM contents
  logic [31:0] gold[int];
  logic [31:0] bmem[int];
  bit          dirty_lines[int];

  function automatic logic [31:0] winit(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] gword(input logic [31:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : winit(a);
  endfunction

  function automatic logic [31:0] bword(input logic [31:0] a);
    return bmem.exists(int'(a)) ? bmem[int'(a)] : winit(a);
  endfunction

  function automatic logic [255:0] gline(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = gword(a + 32'(4*i));
    return l;
  endfunction

  function automatic logic [255:0] bline(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = bword(a + 32'(4*i));
    return l;
  endfunction

  // SRAM model: 2 ways x 16 sets, true LRU per set
  logic [24:0]  s_tag[16][2];
  logic [255:0] s_dat[16][2];
  logic         s_lru[16];
  logic         m_hit, m_way;

  always_comb begin
    m_hit = 1'b0;
    m_way = s_lru[sram_addr_o];
    for (int w = 0; w < 2; w++) begin
      if (s_tag[sram_addr_o][w][24] &&
          s_tag[sram_addr_o][w][22:0] == cpu_addr_i[31:9]) begin
        m_hit = 1'b1;
        m_way = w[0];
      end
    end
    sram_hit_i  = m_hit;
    sram_tag_i  = s_tag[sram_addr_o][m_way];
    sram_data_i = s_dat[sram_addr_o][m_way];
  end

  initial begin
    logic         c_en, c_wr, c_hit, c_way;
    logic [3:0]   c_idx;
    logic [24:0]  c_tag;
    logic [255:0] c_dat;
    for (int s = 0; s < 16; s++) begin
      s_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        s_tag[s][w] = '0;
        s_dat[s][w] = '0;
      end
    end
    forever begin
      @(negedge clk_i);
      c_en = sram_enable_o; c_wr = sram_write_o; c_idx = sram_addr_o;
      c_hit = sram_hit_i; c_way = m_way;
      c_tag = sram_tag_o; c_dat = sram_data_o;
      @(posedge clk_i);
      if (!rst_i && c_en) begin
        if (c_wr) begin
          s_tag[c_idx][c_way] = c_tag;
          s_dat[c_idx][c_way] = c_dat;
          s_lru[c_idx] = ~c_way;
        end else if (c_hit) begin
          s_lru[c_idx] = ~c_way;
        end
      end
    end
  end

  // Memory responder: random 1..4 cycle latency, one-cycle ack
  typedef struct {
    bit          wr;
    logic [31:0] addr;
  } tx_t;
  tx_t  txlog[$];
  int   m_cnt = 0;
  int   m_lat = 0;
  int   lat_sum = 0;
  int   lat_force = 0;
  bit   force_ack = 0;

  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (rst_i) begin
        m_cnt = 0;
      end else if (mem_enable_o) begin
        if (m_cnt == 0)
          m_lat = (lat_force != 0) ? lat_force : $urandom_range(1, 4);
        m_cnt++;
        if (m_cnt == m_lat) begin
          m_cnt = 0;
          lat_sum += m_lat;
          mem_ack_i = 1'b1;
          txlog.push_back('{mem_write_o, mem_addr_o});
          if (mem_write_o) begin
            chk("wb_dirty", 256'(dirty_lines.exists(int'(mem_addr_o))), 1);
            chk("wb_data", mem_data_o, gline(mem_addr_o));
            for (int i = 0; i < 8; i++)
              bmem[int'(mem_addr_o) + 4*i] = mem_data_o[32*i +: 32];
            dirty_lines.delete(int'(mem_addr_o));
          end else begin
            chk("rf_addr", mem_addr_o, {cpu_addr_i[31:5], 5'b0});
            chk("rf_clean", 256'(dirty_lines.exists(int'(mem_addr_o))), 0);
            mem_data_i = bline(mem_addr_o);
          end
        end
      end else if (force_ack) begin
        force_ack  = 0;
        mem_ack_i  = 1'b1;
        mem_data_i = {8{$urandom()}};
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
  endtask

  // One access; exp_stall: 1 miss, 0 hit, -1 unknown
  task automatic access(input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_stall);
    int st;
    bit done;
    logic [31:0] line;
    line = {addr[31:5], 5'b0};
    @(posedge clk_i);
    #2;
    cpu_req_i = 1'b1; cpu_write_i = wr;
    cpu_addr_i = addr; cpu_data_i = data;
    lat_sum = 0; txlog.delete();
    st = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk_i);
      if (cpu_stall_o) begin
        st++;
      end else begin
        done = 1;
        if (wr) begin
          gold[int'(addr)] = data;
          dirty_lines[int'(line)] = 1;
          chk("st_we", 256'(sram_write_o), 1);
          chk("st_tag", 256'(sram_tag_o), 256'({2'b11, addr[31:9]}));
          chk("st_line", sram_data_o, gline(line));
        end else begin
          chk("ld_data", 256'(cpu_data_o), 256'(gword(addr)));
          chk("ld_nowe", 256'(sram_write_o), 0);
        end
      end
    end
    if (!done) begin
      chk("timeout", 0, 1);
      do_reset();
    end else begin
      if (st > 0) chk("miss_lat", st, 3 + lat_sum);
      else chk("hit_nomem", lat_sum, 0);
      if (exp_stall >= 0) chk("stall", 256'(st != 0), exp_stall);
    end
    @(posedge clk_i);
    #2 cpu_req_i = 1'b0;
  endtask

  initial begin
    int nwr;
    bit reached;
    rst_i = 1'b1;
    cpu_req_i = 1'b0; cpu_write_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_stall", 256'(cpu_stall_o), 0);
    chk("rst_men", 256'(mem_enable_o), 0);
    chk("rst_mwr", 256'(mem_write_o), 0);
    chk("rst_sen", 256'(sram_enable_o), 0);
    @(posedge clk_i);
    #2 rst_i = 1'b0;

    // Cold miss, then hit on word 1
    gold[32'h24] = 32'hDEADBEEF;
    bmem[32'h24] = 32'hDEADBEEF;
    access(0, 32'h20, 0, 1);
    chk("cold_n", txlog.size(), 1);
    if (txlog.size() == 1) begin
      chk("cold_wr", 256'(txlog[0].wr), 0);
      chk("cold_addr", 256'(txlog[0].addr), 32'h20);
    end
    access(0, 32'h24, 0, 0);
    chk("deadbeef", 256'(cpu_data_o), 32'hDEADBEEF);

    // Store hit: one-cycle SRAM write
    access(1, 32'h24, 32'h12345678, 0);
    @(negedge clk_i);
    chk("st_once", 256'(sram_write_o), 0);

    // Fill second way of set 1, then evict the dirty 0x020 line
    access(0, 32'h220, 0, 1);
    access(0, 32'h420, 0, 1);
    chk("ev_n", txlog.size(), 2);
    if (txlog.size() == 2) begin
      chk("ev_wb", 256'({txlog[0].wr, txlog[0].addr}), {1'b1, 32'h20});
      chk("ev_rf", 256'({txlog[1].wr, txlog[1].addr}), {1'b0, 32'h420});
    end
    chk("ev_mem", 256'(bword(32'h24)), 32'h12345678);

    // Clean victim (0x220): no write-back
    access(0, 32'h20, 0, 1);
    nwr = 0;
    foreach (txlog[i]) if (txlog[i].wr) nwr++;
    chk("clean_nowb", nwr, 0);
    chk("clean_n", txlog.size(), 1);

    // Reset while in WRITEBACK
    access(0, 32'h40, 0, 1);
    access(1, 32'h44, 32'hCAFEF00D, 0);
    access(0, 32'h240, 0, 1);
    lat_force = 4;
    @(posedge clk_i);
    #2;
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h440;
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge clk_i);
      if (mem_enable_o && mem_write_o) reached = 1;
    end
    chk("wb_reach", 256'(reached), 1);
    #1 rst_i = 1'b1;
    #1;
    chk("rwb_men", 256'(mem_enable_o), 0);
    chk("rwb_stall", 256'(cpu_stall_o), 0);
    chk("rwb_mwr", 256'(mem_write_o), 0);
    cpu_req_i = 1'b0;
    lat_force = 0;
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rwb_idle_st", 256'(cpu_stall_o), 0);
    chk("rwb_idle_me", 256'(mem_enable_o), 0);

    // Spurious ack in IDLE
    force_ack = 1;
    @(negedge clk_i);
    chk("sp_ack", 256'(mem_ack_i), 1);
    chk("sp_swr", 256'(sram_write_o), 0);
    chk("sp_men", 256'(mem_enable_o), 0);
    @(negedge clk_i);
    chk("sp_stall", 256'(cpu_stall_o), 0);
    chk("sp_men2", 256'(mem_enable_o), 0);
    access(0, 32'h44, 0, 0);

    // Random traffic over 4 tags x 4 sets
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = {21'(0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'b00};
      access(bit'($urandom_range(0, 1)), a, $urandom(), -1);
      if ($urandom_range(0, 3) == 0) @(negedge clk_i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Cache controller in front of the 2-way, 16-set, 256-bit-line data-cache SRAM.
- Takes 32-bit word load/store requests from the MEM pipeline stage and decodes tag/index/offset.
- Drives the SRAM's set index, tag, line data, enable and write controls.
- On a miss: stalls the pipeline, writes back a dirty victim, refills the line from data memory, then lets the access retire as a hit.

Parameters:
- None; geometry fixed: 32-bit address, 23-bit tag, 4-bit index, 5-bit byte offset, 256-bit line.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- cpu_req_i  in  1  load/store request valid
- cpu_write_i  in  1  1=store, 0=load
- cpu_addr_i  in  32  byte address: tag [31:9], index [8:5], word [4:2]
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  pipeline stall
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write strobe
- sram_tag_i  in  25  on hit: hit way's tag; on miss: LRU victim's tag
- sram_data_i  in  256  line of hit way or victim
- sram_hit_i  in  1  valid tag match in the set
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1=write-back, 0=refill
- mem_addr_o  out  32  line-aligned address, [4:0]=0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line, valid in the ack cycle
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Reset: rst_i, asynchronous, active-high; clock clk_i. Reset forces state IDLE; mem_enable_o=0, mem_write_o=0, cpu_stall_o=0; internal refill/victim registers cleared. Reset mid-miss abandons the transaction immediately (no ack awaited).
- Signal encoding:
  - sram_addr_o = cpu_addr_i[8:5] always.
  - sram_enable_o = cpu_req_i in IDLE; 1 in all other states.
  - cpu_data_o = sram_data_i[32*w +: 32], where w = cpu_addr_i[4:2]; combinational.
- States: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
- IDLE:
  - Read hit: zero added latency, cpu_stall_o=0.
  - Write hit: sram_write_o=1; sram_data_o = sram_data_i with word w replaced by cpu_data_i; sram_tag_o = {1, 1, cpu tag}. Completes the same cycle, no stall.
  - cpu_req_i && !sram_hit_i: cpu_stall_o=1; next state MISS.
  - No request: sram_write_o=0.
- MISS: capture victim line and victim tag from the SRAM.
  - Victim valid && dirty: next WRITEBACK.
  - Otherwise: next REFILL.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = captured victim line.
  - Outputs held until mem_ack_i; then next REFILL.
- REFILL:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {cpu tag, index, 5'b0}.
  - On mem_ack_i: register mem_data_i; next REFILL_DONE.
- REFILL_DONE:
  - sram_write_o=1, sram_data_o = refill line, sram_tag_o = {1, 0, cpu tag}. The SRAM places it in the LRU way.
  - Next state IDLE. The access is replayed there and hits; a store then merges as a normal write hit.
- cpu_stall_o = 1 in every state except IDLE. In IDLE, cpu_stall_o = cpu_req_i && !sram_hit_i.
- mem_enable_o is a level signal, deasserted the cycle after ack. mem_ack_i is ignored in IDLE, MISS and REFILL_DONE.
- Minimum miss latency:
  - Clean victim: 3 cycles + memory latency.
  - Dirty victim: adds one full memory round-trip.
- Upstream holds cpu_req_i, cpu_addr_i, cpu_write_i and cpu_data_i stable while cpu_stall_o=1.

Test Plan:
- After reset, load 0x0000_0020 (cold miss):
  - Required: stall; REFILL issues mem_addr_o=0x20, mem_write_o=0.
  - Ack with line word1=0xDEADBEEF; load 0x24 then returns 0xDEADBEEF, no stall.
- Store 0x1234_5678 to 0x24 after fill:
  - Required: no stall; sram_write_o=1 one cycle; sram_tag_o[24:23]=2'b11; word1 updated, other words unchanged.
- Fill both ways of set 1 (0x020, 0x220), dirty 0x020, then load 0x420:
  - Required: WRITEBACK to 0x20 with the dirty line, then REFILL at 0x420.
  - Stall deasserts only after both acks plus REFILL_DONE.
- Miss with a clean victim:
  - Required: no write-back; mem_write_o never asserts.
- Assert rst_i while in WRITEBACK:
  - Required: mem_enable_o=0 and cpu_stall_o=0 immediately; state IDLE.
- Spurious mem_ack_i in IDLE:
  - Required: no state change, no SRAM write.
